// File: rtl/per_bus_pkg.sv
// Shared types and constants for the peripheral bus arbiter: FSM states, region map,
// per-region wait states and the unmapped-access read value.
package per_bus_pkg;

   typedef enum logic [1:0] {StIdle, StAccess, StAck} state_e;

   localparam logic [3:0] REG_LED  = 4'd1;
   localparam logic [3:0] REG_SPI  = 4'd2;
   localparam logic [3:0] REG_RAM  = 4'd3;
   localparam logic [3:0] REG_IN   = 4'd4;
   localparam logic [3:0] REG_UART = 4'd5;

   // 2 bits per region, region 0 in bits [1:0]; SPI and UART need one wait state.
   localparam logic [31:0] WS_TABLE = 32'h0000_0410;

   localparam logic [31:0] DEAD_BEEF = 32'hDEAD_BEEF;

   function automatic logic [1:0] region_ws(input logic [3:0] region);
      return WS_TABLE[{region, 1'b0} +: 2];
   endfunction

   function automatic logic region_unmapped(input logic [3:0] region);
      return (region == 4'd0) || (region > REG_UART);
   endfunction

endpackage

// File: rtl/per_bus_cs_dec.sv
// Region decoder: 4-bit region plus enable to a 16-bit one-hot-low chip select.
module per_bus_cs_dec (
   input  logic [3:0]  region,
   input  logic        en,
   output logic [15:0] cs_n
);

   always_comb begin
      cs_n = '1;
      if (en) cs_n[region] = 1'b0;
   end

endmodule

// File: rtl/per_bus_arb.sv
// Two-master round-robin arbiter and access sequencer for the peripheral bus.
// Define PER_BUS_ARB_BUS_ERR_EN to terminate unmapped-region accesses with bus_err.
module per_bus_arb
   import per_bus_pkg::*;
#(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic          m0_we,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_ack,
   input  logic          m1_req,
   input  logic          m1_we,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_ack,
   output logic [AW-1:0] bus_addr,
   output logic [DW-1:0] bus_wdata,
   output logic          bus_we,
   input  logic [DW-1:0] bus_rdata,
   output logic [15:0]   bus_cs_n,
`ifdef PER_BUS_ARB_BUS_ERR_EN
   output logic          bus_err,
`endif
   output logic          busy
);

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic          grant_q, grant_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [1:0]    wcnt_q, wcnt_d;
   logic [DW-1:0] m0_rdata_q, m0_rdata_d;
   logic [DW-1:0] m1_rdata_q, m1_rdata_d;
`ifdef PER_BUS_ARB_BUS_ERR_EN
   logic          err_q, err_d;
`endif

   // Tie goes to the master not served last; a lone requester always wins.
   logic          sel;
   logic [AW-1:0] sel_addr;
   logic [3:0]    sel_region;

   assign sel        = (m0_req && m1_req) ? ~last_q : m1_req;
   assign sel_addr   = sel ? m1_addr : m0_addr;
   assign sel_region = sel_addr[AW-1 -: 4];

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_d    = grant_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wcnt_d     = wcnt_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
`ifdef PER_BUS_ARB_BUS_ERR_EN
      err_d      = err_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (m0_req || m1_req) begin
               grant_d = sel;
               we_d    = sel ? m1_we : m0_we;
               addr_d  = sel_addr;
               wdata_d = sel ? m1_wdata : m0_wdata;
               wcnt_d  = region_ws(sel_region);
               state_d = StAccess;
`ifdef PER_BUS_ARB_BUS_ERR_EN
               err_d   = 1'b0;
               if (region_unmapped(sel_region)) begin
                  err_d   = 1'b1;
                  state_d = StAck;
                  if (sel) m1_rdata_d = DW'(DEAD_BEEF);
                  else     m0_rdata_d = DW'(DEAD_BEEF);
               end
`endif
            end
         end
         StAccess: begin
            if (wcnt_q == 2'd0) begin
               if (grant_q) m1_rdata_d = bus_rdata;
               else         m0_rdata_d = bus_rdata;
               state_d = StAck;
            end else begin
               wcnt_d = wcnt_q - 2'd1;
            end
         end
         StAck: begin
            last_d  = grant_q;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         last_q     <= 1'b1;
         grant_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wcnt_q     <= 2'd0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
`ifdef PER_BUS_ARB_BUS_ERR_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wcnt_q     <= wcnt_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
`ifdef PER_BUS_ARB_BUS_ERR_EN
         err_q      <= err_d;
`endif
      end
   end

   per_bus_cs_dec u_cs_dec (
      .region (addr_q[AW-1 -: 4]),
      .en     (state_q == StAccess),
      .cs_n   (bus_cs_n)
   );

   // Strobe only in the last access cycle so side-effecting registers see one write.
   assign bus_we    = (state_q == StAccess) && (wcnt_q == 2'd0) && we_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign m0_ack    = (state_q == StAck) && !grant_q;
   assign m1_ack    = (state_q == StAck) && grant_q;
   assign m0_rdata  = m0_rdata_q;
   assign m1_rdata  = m1_rdata_q;
   assign busy      = (state_q != StIdle);
`ifdef PER_BUS_ARB_BUS_ERR_EN
   assign bus_err   = (state_q == StAck) && err_q;
`endif

endmodule

// File: tb/tb_per_bus_arb.sv
// Directed self-checking bench for per_bus_arb; inputs change and outputs are sampled
// on the falling clock edge.
module tb_per_bus_arb;

   logic        clk;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ack, m1_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_we;
   logic [15:0] bus_cs_n;
   logic        busy;
`ifdef PER_BUS_ARB_BUS_ERR_EN
   logic        bus_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   per_bus_arb #(.AW(32), .DW(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (m0_req),
      .m0_we     (m0_we),
      .m0_addr   (m0_addr),
      .m0_wdata  (m0_wdata),
      .m0_rdata  (m0_rdata),
      .m0_ack    (m0_ack),
      .m1_req    (m1_req),
      .m1_we     (m1_we),
      .m1_addr   (m1_addr),
      .m1_wdata  (m1_wdata),
      .m1_rdata  (m1_rdata),
      .m1_ack    (m1_ack),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_we    (bus_we),
      .bus_rdata (bus_rdata),
      .bus_cs_n  (bus_cs_n),
`ifdef PER_BUS_ARB_BUS_ERR_EN
      .bus_err   (bus_err),
`endif
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   logic [7:0] exp_ack0;
   logic [7:0] exp_ack1;
   logic [7:0] exp_acc;

   initial begin
      reset = 1'b0;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
      bus_rdata = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_cs_n", 32'(bus_cs_n), 32'h0000_FFFF);
      check_eq("rst_we", 32'(bus_we), 32'd0);
      check_eq("rst_addr", bus_addr, 32'd0);
      check_eq("rst_wdata", bus_wdata, 32'd0);
      check_eq("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
      check_eq("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;

      // m0 read from RAM, zero wait states
      @(negedge clk);
      m0_req = 1; m0_we = 0; m0_addr = 32'h3000_0010; bus_rdata = 32'h1234_5678;
      @(negedge clk);
      check_eq("t1_cs_n", 32'(bus_cs_n), 32'h0000_FFF7);
      check_eq("t1_addr", bus_addr, 32'h3000_0010);
      check_eq("t1_busy", 32'(busy), 32'd1);
      check_eq("t1_ack_early", 32'(m0_ack), 32'd0);
      check_eq("t1_we", 32'(bus_we), 32'd0);
      @(negedge clk);
      check_eq("t1_ack", 32'(m0_ack), 32'd1);
      check_eq("t1_cs_idle", 32'(bus_cs_n), 32'h0000_FFFF);
      check_eq("t1_rdata", m0_rdata, 32'h1234_5678);
      m0_req = 0;
      @(negedge clk);
      check_eq("t1_ack_once", 32'(m0_ack), 32'd0);
      check_eq("t1_idle", 32'(busy), 32'd0);

      // m1 write to SPI, one wait state
      m1_req = 1; m1_we = 1; m1_addr = 32'h2000_0001; m1_wdata = 32'h0000_00A5;
      bus_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      check_eq("t2_cs_n_a", 32'(bus_cs_n), 32'h0000_FFFB);
      check_eq("t2_we_a", 32'(bus_we), 32'd0);
      check_eq("t2_wdata", bus_wdata, 32'h0000_00A5);
      @(negedge clk);
      check_eq("t2_cs_n_b", 32'(bus_cs_n), 32'h0000_FFFB);
      check_eq("t2_we_b", 32'(bus_we), 32'd1);
      check_eq("t2_ack_early", 32'(m1_ack), 32'd0);
      @(negedge clk);
      check_eq("t2_ack", 32'(m1_ack), 32'd1);
      check_eq("t2_we_off", 32'(bus_we), 32'd0);
      check_eq("t2_cs_off", 32'(bus_cs_n), 32'h0000_FFFF);
      check_eq("t2_m0_hold", m0_rdata, 32'h1234_5678);
      m1_req = 0; m1_we = 0;
      @(negedge clk);

      // Both request and hold: m0, m1, m0 with alternating acks
      exp_ack0 = 8'b1000_0010;
      exp_ack1 = 8'b0001_0000;
      exp_acc  = 8'b0100_1001;
      m0_req = 1; m0_we = 0; m0_addr = 32'h3000_0000;
      m1_req = 1; m1_we = 0; m1_addr = 32'h3000_0004;
      bus_rdata = 32'hCAFE_0001;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check_eq($sformatf("t3_ack0_%0d", i), 32'(m0_ack), 32'(exp_ack0[i]));
         check_eq($sformatf("t3_ack1_%0d", i), 32'(m1_ack), 32'(exp_ack1[i]));
         check_eq($sformatf("t3_cs_%0d", i), 32'(bus_cs_n),
                  exp_acc[i] ? 32'h0000_FFF7 : 32'h0000_FFFF);
         if (i == 3) check_eq("t3_addr_m1", bus_addr, 32'h3000_0004);
         if (i == 6) check_eq("t3_addr_m0", bus_addr, 32'h3000_0000);
      end
      m0_req = 0; m1_req = 0;
      check_eq("t3_m1_rdata", m1_rdata, 32'hCAFE_0001);
      @(negedge clk);
      check_eq("t3_idle", 32'(busy), 32'd0);

      // Reset in the middle of a UART write
      m1_req = 1; m1_we = 1; m1_addr = 32'h5000_0000; m1_wdata = 32'h0000_0055;
      @(negedge clk);
      check_eq("t4_cs_n", 32'(bus_cs_n), 32'h0000_FFDF);
      #2 reset = 1'b0;
      #1;
      check_eq("t4_rst_cs", 32'(bus_cs_n), 32'h0000_FFFF);
      check_eq("t4_rst_we", 32'(bus_we), 32'd0);
      check_eq("t4_rst_busy", 32'(busy), 32'd0);
      check_eq("t4_rst_addr", bus_addr, 32'd0);
      check_eq("t4_rst_rdata", m1_rdata, 32'd0);
      @(negedge clk);
      m1_req = 0; m1_we = 0;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_eq($sformatf("t4_no_ack_%0d", i), {30'd0, m1_ack, m0_ack}, 32'd0);
      end
      m0_req = 1; m0_we = 1; m0_addr = 32'h1000_0004; m0_wdata = 32'h0000_0077;
      @(negedge clk);
      check_eq("t4_cs_led", 32'(bus_cs_n), 32'h0000_FFFD);
      check_eq("t4_we_led", 32'(bus_we), 32'd1);
      check_eq("t4_wdata_led", bus_wdata, 32'h0000_0077);
      @(negedge clk);
      check_eq("t4_ack_led", 32'(m0_ack), 32'd1);
      m0_req = 0; m0_we = 0;
      @(negedge clk);

`ifdef PER_BUS_ARB_BUS_ERR_EN
      // Unmapped region terminates with bus_err one cycle after sampling
      m0_req = 1; m0_we = 0; m0_addr = 32'h7000_0000;
      @(negedge clk);
      check_eq("t5_cs_n", 32'(bus_cs_n), 32'h0000_FFFF);
      check_eq("t5_ack", 32'(m0_ack), 32'd1);
      check_eq("t5_err", 32'(bus_err), 32'd1);
      check_eq("t5_rdata", m0_rdata, 32'hDEAD_BEEF);
      m0_req = 0;
      @(negedge clk);
      check_eq("t5_err_off", 32'(bus_err), 32'd0);
`else
      // Region 7 is an ordinary zero-wait region
      m0_req = 1; m0_we = 0; m0_addr = 32'h7000_0000; bus_rdata = 32'h0000_7777;
      @(negedge clk);
      check_eq("t5_cs_n", 32'(bus_cs_n), 32'h0000_FF7F);
      @(negedge clk);
      check_eq("t5_ack", 32'(m0_ack), 32'd1);
      check_eq("t5_rdata", m0_rdata, 32'h0000_7777);
      m0_req = 0;
      @(negedge clk);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/per_bus_arb.md
# per_bus_arb

Two-master arbiter and access sequencer for the peripheral bus. The CPU data port (master 0) and a second requester (master 1, e.g. a UART boot loader or DMA engine) each issue single word accesses. The block grants the bus round-robin, drives the shared address/write-data/write-enable lines and the active-low one-hot chip selects (region = addr[31:28]), inserts per-region wait states, and returns read data with a one-cycle acknowledge.

## Interface
Parameters:
- AW, 32, address width; region field is addr[AW-1:AW-4]
- DW, 32, data width

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req / m1_req  in  1  access request, held high until ack
- m0_we / m1_we  in  1  1 = write, 0 = read; stable while req high
- m0_addr / m1_addr  in  AW  byte address; stable while req high
- m0_wdata / m1_wdata  in  DW  write data; stable while req high
- m0_rdata / m1_rdata  out  DW  read data, valid in ack cycle
- m0_ack / m1_ack  out  1  one-cycle completion pulse
- bus_addr  out  AW  shared address to peripherals
- bus_wdata  out  DW  shared write data
- bus_we  out  1  write strobe, one cycle per write
- bus_rdata  in  DW  wired read data from selected peripheral
- bus_cs_n  out  16  one-hot-low chip select, bit = region
- busy  out  1  high in any state other than IDLE

## Operation
- FSM: IDLE, ACCESS, ACK.
- IDLE: sample requests. Only one high -> grant it. Both high -> grant the master not granted last (pointer `last`, reset value 1 so m0 wins first tie). Latch grant, we, addr, wdata; load wait counter with WS[region]; go ACCESS.
- ACCESS: bus_cs_n bit for region low, bus_addr/bus_wdata driven from latch. Counter decrements each cycle; when 0 this is the final ACCESS cycle: bus_we = latched we, bus_rdata captured into granted master's rdata register; go ACK.
- ACK: granted master's ack high for one cycle; `last` <- grant; requests ignored; go IDLE.
- Non-granted master sees no ack and keeps waiting; no starvation: a continuously requesting loser is served next.
- Wait states are 2-bit per region, from package table: region 3 (RAM) 0, regions 2 (SPI) and 5 (UART) 1, all others 0.
- m*_rdata of the non-granted master holds its previous value.
- Reset values: bus_cs_n = 16'hFFFF, bus_we 0, bus_addr 0, bus_wdata 0, acks 0, rdata 0, busy 0, state IDLE, last 1.

## Timing
- Request sampled at edge T (state IDLE) -> cs_n low from T+1 for 1+WS cycles -> ack high for exactly one cycle at T+2+WS.
- Zero-wait access: 3 cycles req-to-ack-cycle-end; minimum issue interval per master 3 cycles.
- bus_we high only in the final ACCESS cycle, so side-effecting registers (UART tx, SPI shift) see exactly one write.
- Outside ACCESS: bus_cs_n all ones, bus_we 0; bus_addr/bus_wdata hold last values.
- Master dropping req mid-access: access still completes and acks (masters must not abort).
- Reset asserted mid-access: all outputs return to reset values asynchronously; the access is lost, no ack.

## Configuration
- PER_BUS_ARB_BUS_ERR_EN defined: regions 0 and 6–F are unmapped; an access to them skips ACCESS (no cs_n, no we), goes directly to ACK, returns rdata 32'hDEAD_BEEF and pulses extra output port bus_err (1 bit, reset 0) with the ack.
- Not defined: every region is accessed normally; bus_err port absent.

## Structure
- Package per_bus_pkg: state enum (IDLE, ACCESS, ACK), region index constants (REG_LED 1, REG_SPI 2, REG_RAM 3, REG_IN 4, REG_UART 5), 16×2-bit wait-state table, DEAD_BEEF constant.
- One sub-module: per_bus_cs_dec, combinational 4-bit region + enable -> 16-bit one-hot-low select.

## Test plan
- m0 read addr 0x3000_0010, bus_rdata 0x1234_5678 -> cs_n = 16'hFFF7 for 1 cycle, m0_ack 2 cycles after, m0_rdata 0x1234_5678.
- m1 write 0x2000_0001 data 0xA5 -> cs_n bit 2 low 2 cycles, bus_we high only second cycle, m1_ack next cycle.
- m0 and m1 request same cycle, both held -> m0 served first, m1 next, then m0; acks alternate, never two acks in one cycle.
- Reset low during ACCESS of a UART write -> cs_n 16'hFFFF and bus_we 0 immediately, no ack; after release, new request completes normally.
- With PER_BUS_ARB_BUS_ERR_EN, m0 read 0x7000_0000 -> no cs_n activity, m0_ack and bus_err high together one cycle after sample, rdata 0xDEAD_BEEF.
